// File: rtl/datapath_pkg.sv
// Shared types for the signed arithmetic datapath and its issue sequencer.
package datapath_pkg;

   localparam int DP_N     = 16;
   localparam int OPCODE_W = 3;

   typedef struct packed {
      logic signed [DP_N-1:0]   a;
      logic signed [DP_N-1:0]   b;
      logic [OPCODE_W-1:0]      op;
   } dp_cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2
   } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered single-clock FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/datapath_op_sequencer.sv
// Issue stage: queues commands, drives the combinational datapath from the FIFO head, registers results.
module datapath_op_sequencer
   import datapath_pkg::*;
#(
   parameter  int N     = 16,
   parameter  int DEPTH = 4,
   parameter  int CNT_W = 16,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        in_a,
   input  logic [N-1:0]        in_b,
   input  logic [OPCODE_W-1:0] in_opcode,
   output logic [N-1:0]        dp_a,
   output logic [N-1:0]        dp_b,
   output logic [OPCODE_W-1:0] dp_opcode,
   input  logic [N-1:0]        dp_y,
   input  logic                dp_co,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N-1:0]        out_y,
   output logic                out_co,
   output logic [OPCODE_W-1:0] out_opcode,
   output logic [CW-1:0]       fifo_count,
   output logic [1:0]          state,
   output logic [CNT_W-1:0]    ops_done
);

   typedef struct packed {
      logic [N-1:0]        a;
      logic [N-1:0]        b;
      logic [OPCODE_W-1:0] op;
   } cmd_t;

   cmd_t       wr_cmd;
   cmd_t       head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       issue;
   logic       out_hs;
   logic [CW-1:0] count_nxt;
   logic       out_valid_nxt;
   seq_state_t state_q;
   seq_state_t state_d;

   assign wr_cmd = '{a: in_a, b: in_b, op: in_opcode};

   sync_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (wr_cmd),
      .rd_en   (issue),
      .rd_data (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Readiness ignores a same-cycle pop: no fall-through path from output to input.
   assign in_ready  = !fifo_full;
   assign push      = in_valid && in_ready;
   assign issue     = !fifo_empty && (!out_valid || out_ready);
   assign out_hs    = out_valid && out_ready;

   assign dp_a      = fifo_empty ? '0 : head.a;
   assign dp_b      = fifo_empty ? '0 : head.b;
   assign dp_opcode = fifo_empty ? '0 : head.op;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_y      <= '0;
         out_co     <= 1'b0;
         out_opcode <= '0;
         ops_done   <= '0;
      end else begin
         if (issue) begin
            out_valid  <= 1'b1;
            out_y      <= dp_y;
            out_co     <= dp_co;
            out_opcode <= dp_opcode;
         end else if (out_hs) begin
            out_valid  <= 1'b0;
         end
         if (out_hs) ops_done <= ops_done + CNT_W'(1);
      end
   end

   // State tracks the occupancy the datapath will have after this edge.
   assign count_nxt     = fifo_count + CW'(push) - CW'(issue);
   assign out_valid_nxt = issue || (out_valid && !out_ready);

   always_comb begin
      state_d = S_RUN;
      if (count_nxt == '0 && !out_valid_nxt)
         state_d = S_IDLE;
      else if (out_valid_nxt && !out_ready && count_nxt == CW'(DEPTH))
         state_d = S_STALL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   assign state = state_q;

endmodule
